// File: rtl/cail_tx_pkg.sv
// Shared types and constants for the calibration result framer.
// CAIL_TX_CHECKSUM_EN adds the CSUM state to the FSM encoding.
package cail_tx_pkg;
  localparam int          WORD_W       = 32;
  localparam logic [7:0]  HDR0_DEFAULT = 8'hA5;
  localparam logic [7:0]  HDR1_DEFAULT = 8'h5A;

`ifdef CAIL_TX_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_LEN_H, S_LEN_L, S_DATA, S_CSUM} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_LEN_H, S_LEN_L, S_DATA} state_e;
`endif
endpackage

// File: rtl/cail_tx_fifo.sv
// Count-based synchronous FIFO with first-word fall-through read port.
module cail_tx_fifo import cail_tx_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int W     = WORD_W
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_wr, w_do_rd;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  // A read on an empty FIFO with a concurrent write passes the new word through.
  assign w_do_wr = wr_en && (!full || rd_en);
  assign w_do_rd = rd_en && (!empty || wr_en);
  assign rd_data = empty ? wr_data : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/cail_result_tx.sv
// Frames buffered calibration results into a byte stream: A5 5A len_h len_l data...
// Define CAIL_TX_CHECKSUM_EN to append a mod-256 sum of length and data bytes.
module cail_result_tx import cail_tx_pkg::*; #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HDR0       = HDR0_DEFAULT,
  parameter logic [7:0] HDR1       = HDR1_DEFAULT
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cail_en,
  input  logic [15:0] data_len,
  input  logic        valid,
  input  logic [31:0] result,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overflow
);
  state_e            r_state, w_next;
  logic [15:0]       r_len, r_wr_cnt, r_tx_cnt;
  logic [1:0]        r_byte;
  logic              r_ovf;
  logic [WORD_W-1:0] w_head;
  logic              w_full, w_empty, w_hs, w_pop, w_start, w_last_word, w_wr_req, w_wr_en;

  assign busy        = (r_state != S_IDLE);
  assign overflow    = r_ovf;
  assign w_start     = (r_state == S_IDLE) && cail_en && (data_len != 16'd0);
  assign w_hs        = tx_valid && tx_ready;
  assign w_pop       = (r_state == S_DATA) && w_hs && (r_byte == 2'd0);
  assign w_last_word = (r_tx_cnt == r_len - 16'd1);
  // Words beyond the frame length are dropped without flagging overflow.
  assign w_wr_req    = valid && busy && (r_wr_cnt < r_len);
  assign w_wr_en     = w_wr_req && (!w_full || w_pop);

  cail_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_data (result),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

`ifdef CAIL_TX_CHECKSUM_EN
  logic [7:0] r_csum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_csum <= 8'h00;
    else if (w_start) r_csum <= 8'h00;
    else if (w_hs && (r_state inside {S_LEN_H, S_LEN_L, S_DATA}))
      r_csum <= r_csum + tx_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_HDR0;
      S_HDR0:  begin tx_valid = 1'b1; tx_data = HDR0;        if (tx_ready) w_next = S_HDR1;  end
      S_HDR1:  begin tx_valid = 1'b1; tx_data = HDR1;        if (tx_ready) w_next = S_LEN_H; end
      S_LEN_H: begin tx_valid = 1'b1; tx_data = r_len[15:8]; if (tx_ready) w_next = S_LEN_L; end
      S_LEN_L: begin tx_valid = 1'b1; tx_data = r_len[7:0];  if (tx_ready) w_next = S_DATA;  end
      S_DATA: begin
        // Head word stays put until its last byte goes, so data is stable under stall.
        tx_valid = !w_empty;
        tx_data  = w_head[8*r_byte +: 8];
`ifdef CAIL_TX_CHECKSUM_EN
        if (w_pop && w_last_word) w_next = S_CSUM;
`else
        if (w_pop && w_last_word) w_next = S_IDLE;
`endif
      end
`ifdef CAIL_TX_CHECKSUM_EN
      S_CSUM:  begin tx_valid = 1'b1; tx_data = r_csum;      if (tx_ready) w_next = S_IDLE;  end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len    <= 16'd0;
      r_wr_cnt <= 16'd0;
      r_tx_cnt <= 16'd0;
      r_byte   <= 2'd3;
      r_ovf    <= 1'b0;
    end else if (w_start) begin
      r_len    <= data_len;
      r_wr_cnt <= 16'd0;
      r_tx_cnt <= 16'd0;
      r_byte   <= 2'd3;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_wr_req && w_full && !w_pop) r_ovf <= 1'b1;
      if ((r_state == S_DATA) && w_hs) begin
        r_byte <= r_byte - 2'd1;
        if (w_pop) r_tx_cnt <= r_tx_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_cail_result_tx.sv
// Randomized + directed bench for cail_result_tx with a frame-level reference model.
module tb_cail_result_tx;
  localparam int DEPTH = 8;
`ifdef CAIL_TX_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cail_en = 1'b0;
  logic [15:0] data_len = 16'd0;
  logic        valid = 1'b0;
  logic [31:0] result = 32'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;

  cail_result_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cail_en(cail_en), .data_len(data_len),
    .valid(valid), .result(result), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  bit          m_busy, m_ovf, m_lost;
  int          m_len, m_acc, m_sent, m_bi;
  logic [7:0]  m_csum;
  logic [7:0]  m_pre[$];
  logic [31:0] m_fifo[$];
  logic [7:0]  rx[$];
  bit          p_stall;
  logic [7:0]  p_data;

  task automatic model_reset();
    m_busy = 0; m_ovf = 0; m_lost = 0;
    m_len = 0; m_acc = 0; m_sent = 0; m_bi = 0; m_csum = 8'h00;
    m_pre.delete(); m_fifo.delete();
  endtask

  initial model_reset();

  // Compare at negedge: outputs are settled and inputs are those the next posedge samples.
  always @(negedge clk) begin
    bit ev, hs, pop, bnow;
    logic [7:0] eb;
    logic [31:0] w;
    if (!rst_n) begin
      model_reset();
      p_stall = 0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_ovf", overflow, 0);
    end else begin
      ev = 0; eb = 8'h00;
      if (!m_busy) ev = 0;
      else if (m_pre.size() > 0) begin ev = 1; eb = m_pre[0]; end
      else if (m_sent < m_len) begin
        ev = (m_fifo.size() > 0);
        if (ev) begin w = m_fifo[0]; eb = 8'(w >> (24 - 8*m_bi)); end
      end else begin ev = 1; eb = m_csum; end

      chk("busy", busy, m_busy);
      chk("overflow", overflow, m_ovf);
      chk("tx_valid", tx_valid, ev);
      if (ev) chk("tx_data", tx_data, eb);
      if (p_stall) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, p_data);
      end
      p_stall = tx_valid && !tx_ready;
      p_data  = tx_data;
      if (tx_valid && tx_ready) rx.push_back(tx_data);

      // advance the model over the coming posedge
      bnow = m_busy;
      hs = ev && tx_ready;
      pop = 0;
      if (hs) begin
        if (m_pre.size() > 0) begin
          if (m_pre.size() <= 2) m_csum += eb;
          void'(m_pre.pop_front());
        end else if (m_sent < m_len) begin
          m_csum += eb;
          m_bi++;
          if (m_bi == 4) begin
            m_bi = 0; m_sent++; pop = 1;
            if (m_sent == m_len && !CSUM) m_busy = 0;
          end
        end else m_busy = 0;
      end
      if (pop) void'(m_fifo.pop_front());
      if (valid && bnow && m_acc < m_len) begin
        if (m_fifo.size() < DEPTH) begin m_fifo.push_back(result); m_acc++; end
        else begin m_ovf = 1; m_lost = 1; end
      end
      if (cail_en && !bnow && data_len != 16'd0) begin
        m_busy = 1; m_len = int'(data_len); m_acc = 0; m_sent = 0; m_bi = 0;
        m_csum = 8'h00; m_ovf = 0; m_lost = 0;
        m_pre.delete();
        m_pre.push_back(8'hA5); m_pre.push_back(8'h5A);
        m_pre.push_back(data_len[15:8]); m_pre.push_back(data_len[7:0]);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1) tx_ready = ~tx_ready;
    else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #2; endtask

  task automatic start(input int len);
    cail_en = 1; data_len = 16'(len); tick(); cail_en = 0;
  endtask

  task automatic push(input logic [31:0] w);
    valid = 1; result = w; tick(); valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin tick(); c++; end
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); rst_n = 1; tick();
  endtask

  logic [7:0] nom [13] = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                           8'h00, 8'h00, 8'h00, 8'h02, 8'h05};

  task automatic check_nominal(input string tag);
    int n = CSUM ? 13 : 12;
    chk({tag, "_len"}, rx.size(), n);
    for (int i = 0; i < n && i < rx.size(); i++) chk({tag, "_byte"}, rx[i], nom[i]);
  endtask

  initial begin
    int len, n, sent;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx_data", tx_data, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    rst_n = 1; tick();

    // nominal frame
    rx.delete();
    start(2);
    chk("start_busy", busy, 1);
    chk("start_valid", tx_valid, 1);
    chk("start_hdr0", tx_data, 8'hA5);
    push(32'h1); push(32'h2);
    wait_idle(200);
    chk("nom_idle", busy, 0);
    check_nominal("nom");

    // backpressure
    rx.delete();
    tx_ready = 0; rdy_mode = 1;
    start(2); push(32'h1); push(32'h2);
    wait_idle(400);
    rdy_mode = 0; tx_ready = 1;
    chk("bp_idle", busy, 0);
    check_nominal("bp");

    // overflow
    rx.delete();
    tx_ready = 0;
    start(10);
    for (int i = 0; i < 10; i++) begin
      push(32'h100 + i);
      if (i == 7) chk("ovf_before", overflow, 0);
      if (i == 8) chk("ovf_9th", overflow, 1);
    end
    tx_ready = 1;
    repeat (60) tick();
    chk("ovf_sent", rx.size(), 36);
    chk("ovf_stall_busy", busy, 1);
    chk("ovf_stall_valid", tx_valid, 0);
    do_reset();

    // zero length
    rx.delete();
    start(0);
    repeat (5) tick();
    chk("len0_busy", busy, 0);
    chk("len0_bytes", rx.size(), 0);

    // cail_en while busy
    rx.delete();
    start(2); tick(); start(5);
    push(32'h1); push(32'h2);
    wait_idle(200);
    chk("mid_idle", busy, 0);
    check_nominal("mid");

    // excess results
    rx.delete();
    start(1); push(32'hDEADBEEF); push(32'h1); push(32'h2);
    wait_idle(200);
    chk("exc_idle", busy, 0);
    chk("exc_ovf", overflow, 0);
    chk("exc_bytes", rx.size(), CSUM ? 9 : 8);
    chk("exc_empty", dut.w_empty, 1);

    // reset mid-frame
    rx.delete();
    start(2); push(32'h11223344); push(32'h55667788);
    n = 0;
    while (rx.size() < 5 && n < 50) begin tick(); n++; end
    chk("rstm_byte2", tx_data, 8'h22);
    rst_n = 0; #1;
    chk("rstm_valid", tx_valid, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_data", tx_data, 0);
    chk("rstm_ovf", overflow, 0);
    tick(); rst_n = 1; tick();
    rx.delete();
    start(1);
    chk("rstm_restart", tx_data, 8'hA5);
    push(32'hCAFEF00D);
    wait_idle(200);
    chk("rstm_first", rx.size() > 0 ? rx[0] : 8'h00, 8'hA5);
    chk("rstm_bytes", rx.size(), CSUM ? 9 : 8);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 12);
      rdy_mode = 2;
      start(len);
      n = len + $urandom_range(0, 2);
      sent = 0;
      while (sent < n) begin
        valid = 1'($urandom_range(0, 1));
        result = $urandom;
        if (valid) sent++;
        if ($urandom_range(0, 15) == 0) begin cail_en = 1; data_len = 16'($urandom_range(0, 20)); end
        tick();
        cail_en = 0;
      end
      valid = 0;
      wait_idle(2000);
      if (busy) begin
        if (!m_lost) chk("rand_timeout", busy, 0);
        do_reset();
      end
    end
    rdy_mode = 0; tx_ready = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
